// File: rtl/bar_graph_renderer.sv
// ============================================================================
// bar_graph_renderer
//
// Pixel source for a 240x135 RGB565 LCD scan. Eight 8-bit channel values are
// snapshotted once per frame and drawn as horizontal bars, one lane per
// channel. The lane starts with a colour swatch, and the bar follows it.
// An optional peak-hold marker is drawn in white per channel.
//
// Configuration macro:
//   BAR_PEAK_HOLD_EN - when defined, builds the peak/hold registers, the
//                      per-frame update FSM and the marker rendering.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   asynchronous active-high reset
//   in_0..in_7   in   8   channel values, sampled only at frame start
//   row          in   8   scan row    (0..134)
//   column       in   8   scan column (0..239)
//   pixel        out 16   RGB565 colour for (row, column), registered
//   frame_tick   out  1   one-cycle pulse per detected frame start
// ============================================================================
module bar_graph_renderer #(
    parameter int BLOCKWIDTH  = 16,
    parameter int HOLD_FRAMES = 30,
    parameter int DECAY       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_0,
    input  logic [7:0]  in_1,
    input  logic [7:0]  in_2,
    input  logic [7:0]  in_3,
    input  logic [7:0]  in_4,
    input  logic [7:0]  in_5,
    input  logic [7:0]  in_6,
    input  logic [7:0]  in_7,
    input  logic [7:0]  row,
    input  logic [7:0]  column,
    output logic [15:0] pixel,
    output logic        frame_tick
);

    // Fixed channel palette, indexed by lane
    function automatic logic [15:0] chan_colour(input logic [2:0] k);
        logic [15:0] c;
        case (k)
            3'd0:    c = 16'hF800;
            3'd1:    c = 16'hFD20;
            3'd2:    c = 16'hFF40;
            3'd3:    c = 16'h3FE0;
            3'd4:    c = 16'h07FD;
            3'd5:    c = 16'h069F;
            3'd6:    c = 16'h029F;
            3'd7:    c = 16'hD81F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Scale an 8-bit value onto the 224-column bar area (0..223)
    function automatic logic [7:0] scale_len(input logic [7:0] v);
        return 8'((11'(v) * 11'd7) >> 3);
    endfunction

    logic [7:0]  w_in [8];
    logic [7:0]  r_snap [8];
    logic [7:0]  r_prev_row;
    logic [7:0]  r_prev_col;
    logic        w_frame_start;
    logic        w_at_origin;
    logic        w_prev_origin;
    logic [7:0]  w_lane_idx;
    logic [7:0]  w_lane_off;
    logic [2:0]  w_ch;
    logic [7:0]  w_bar_len;
    logic [7:0]  w_bar_pos;
    logic        w_marker;
    logic [15:0] w_pixel_next;

    assign w_in[0] = in_0;
    assign w_in[1] = in_1;
    assign w_in[2] = in_2;
    assign w_in[3] = in_3;
    assign w_in[4] = in_4;
    assign w_in[5] = in_5;
    assign w_in[6] = in_6;
    assign w_in[7] = in_7;

    assign w_at_origin   = (row == 8'd0) && (column == 8'd0);
    assign w_prev_origin = (r_prev_row == 8'd0) && (r_prev_col == 8'd0);

    assign w_lane_idx = row / 8'(BLOCKWIDTH);
    assign w_lane_off = row % 8'(BLOCKWIDTH);
    assign w_ch       = w_lane_idx[2:0];
    assign w_bar_len  = scale_len(r_snap[w_ch]);
    assign w_bar_pos  = column - 8'(BLOCKWIDTH);

`ifdef BAR_PEAK_HOLD_EN
    typedef enum logic [0:0] {ST_IDLE, ST_UPD} state_t;

    state_t      r_state;
    logic [2:0]  r_upd_ch;
    logic [7:0]  r_peak [8];
    logic [7:0]  r_hold [8];
    logic [8:0]  w_dec9;
    logic [7:0]  w_decayed;
    logic [7:0]  w_cur_snap;
    logic [7:0]  w_cur_peak;

    // A frame start arriving while peaks are still updating is ignored
    assign w_frame_start = w_at_origin && !w_prev_origin && (r_state == ST_IDLE);
    assign w_marker      = (column == (8'(BLOCKWIDTH) + scale_len(r_peak[w_ch])));

    assign w_cur_snap = r_snap[r_upd_ch];
    assign w_cur_peak = r_peak[r_upd_ch];
    // Decay in 9 bits: a borrow into bit 8 means the peak would go negative
    assign w_dec9     = {1'b0, w_cur_peak} - 9'(DECAY);
    assign w_decayed  = w_dec9[8] ? 8'd0 : w_dec9[7:0];

    // Peak update FSM: one channel per cycle after each accepted frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_upd_ch <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_peak[i] <= 8'd0;
                r_hold[i] <= 8'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state  <= ST_UPD;
                        r_upd_ch <= 3'd0;
                    end
                end
                ST_UPD: begin
                    if (w_cur_snap >= w_cur_peak) begin
                        r_peak[r_upd_ch] <= w_cur_snap;
                        r_hold[r_upd_ch] <= 8'(HOLD_FRAMES);
                    end else if (r_hold[r_upd_ch] != 8'd0) begin
                        r_hold[r_upd_ch] <= r_hold[r_upd_ch] - 8'd1;
                    end else begin
                        r_peak[r_upd_ch] <= (w_decayed > w_cur_snap) ? w_decayed : w_cur_snap;
                    end
                    if (r_upd_ch == 3'd7) begin
                        r_state <= ST_IDLE;
                    end
                    r_upd_ch <= r_upd_ch + 3'd1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_upd_ch <= 3'd0;
                end
            endcase
        end
    end
`else
    assign w_frame_start = w_at_origin && !w_prev_origin;
    assign w_marker      = 1'b0;
`endif

    // Previous scan position, snapshot of the channels and the frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_row <= 8'd0;
            r_prev_col <= 8'd0;
            frame_tick <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_snap[i] <= 8'd0;
            end
        end else begin
            r_prev_row <= row;
            r_prev_col <= column;
            frame_tick <= w_frame_start;
            if (w_frame_start) begin
                for (int i = 0; i < 8; i++) begin
                    r_snap[i] <= w_in[i];
                end
            end
        end
    end

    // Colour for the current scan position; separator rows and anything
    // outside the lanes or the visible width are black
    always_comb begin
        w_pixel_next = 16'h0000;
        if ((row < 8'd135) && (column < 8'd240) && (w_lane_idx < 8'd8) &&
            (w_lane_off != 8'(BLOCKWIDTH - 1))) begin
            if (column < 8'(BLOCKWIDTH)) begin
                w_pixel_next = chan_colour(w_ch);
            end else if (w_marker) begin
                w_pixel_next = 16'hFFFF;
            end else if (w_bar_pos < w_bar_len) begin
                w_pixel_next = chan_colour(w_ch);
            end else begin
                w_pixel_next = 16'h0000;
            end
        end else begin
            w_pixel_next = 16'h0000;
        end
    end

    // Registered pixel output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel <= 16'h0000;
        end else begin
            pixel <= w_pixel_next;
        end
    end

endmodule

// File: tb/tb_bar_graph_renderer.sv
module tb_bar_graph_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7;
    logic [7:0]  row, column;
    logic [15:0] pixel;
    logic        frame_tick;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef BAR_PEAK_HOLD_EN
    localparam logic [15:0] PK   = 16'hFFFF;
    localparam logic        UPDT = 1'b0;
`else
    localparam logic [15:0] PK   = 16'h0000;
    localparam logic        UPDT = 1'b1;
`endif

    bar_graph_renderer #(
        .BLOCKWIDTH (16),
        .HOLD_FRAMES(2),
        .DECAY      (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_0      (in_0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .in_4      (in_4),
        .in_5      (in_5),
        .in_6      (in_6),
        .in_7      (in_7),
        .row       (row),
        .column    (column),
        .pixel     (pixel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  c;
        logic [15:0] e;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic probe(input logic [7:0] r, input logic [7:0] c, output logic [15:0] px);
        @(negedge clk);
        row    = r;
        column = c;
        @(negedge clk);
        px = pixel;
    endtask

    // Leave (0,0), present it once, check the tick, then let the update run
    task automatic frame_start();
        logic [15:0] px;
        probe(8'd1, 8'd0, px);
        @(negedge clk);
        row    = 8'd0;
        column = 8'd0;
        @(negedge clk);
        chk("frame_tick_rise", {15'd0, frame_tick}, 16'd1);
        row    = 8'd0;
        column = 8'd1;
        @(negedge clk);
        chk("frame_tick_fall", {15'd0, frame_tick}, 16'd0);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] px;
        int pk, hd, sv, col;

        reset = 1'b1;
        {in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7} = 64'd0;
        row = 8'd0;
        column = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_pixel", pixel, 16'h0000);
        chk("reset_tick", {15'd0, frame_tick}, 16'd0);
        reset = 1'b0;

        // Sitting at (0,0) after reset is not a frame start
        repeat (3) @(negedge clk);
        chk("no_tick_after_reset", {15'd0, frame_tick}, 16'd0);
        probe(8'd5, 8'd20, px);
        chk("pre_frame_5_20", px, 16'h0000);

        // Static bars: ch0 = 255 (len 223), ch3 = 128 (len 112)
        in_0 = 8'd255;
        in_3 = 8'd128;
        frame_start();

        vecs[0]  = {8'd0,   8'd5,   16'hF800};
        vecs[1]  = {8'd3,   8'd238, 16'hF800};
        vecs[2]  = {8'd15,  8'd100, 16'h0000};
        vecs[3]  = {8'd50,  8'd127, 16'h3FE0};
        vecs[4]  = {8'd50,  8'd128, PK};
        vecs[5]  = {8'd130, 8'd5,   16'h0000};
        vecs[6]  = {8'd0,   8'd239, PK};
        vecs[7]  = {8'd3,   8'd16,  16'hF800};
        vecs[8]  = {8'd20,  8'd16,  PK};
        vecs[9]  = {8'd20,  8'd5,   16'hFD20};
        vecs[10] = {8'd35,  8'd5,   16'hFF40};
        vecs[11] = {8'd66,  8'd3,   16'h07FD};
        vecs[12] = {8'd85,  8'd0,   16'h069F};
        vecs[13] = {8'd100, 8'd15,  16'h029F};
        vecs[14] = {8'd120, 8'd5,   16'hD81F};
        vecs[15] = {8'd127, 8'd5,   16'h0000};
        vecs[16] = {8'd50,  8'd240, 16'h0000};
        vecs[17] = {8'd140, 8'd5,   16'h0000};
        vecs[18] = {8'd47,  8'd10,  16'h0000};
        vecs[19] = {8'd48,  8'd16,  16'h3FE0};
        for (int i = 0; i < 20; i++) begin
            probe(vecs[i].r, vecs[i].c, px);
            chk($sformatf("vec%0d_r%0d_c%0d", i, vecs[i].r, vecs[i].c), px, vecs[i].e);
        end

        // Asynchronous reset mid-scan clears the output immediately
        probe(8'd0, 8'd100, px);
        chk("bar_before_reset", px, 16'hF800);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_pixel", pixel, 16'h0000);
        chk("async_reset_tick", {15'd0, frame_tick}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        probe(8'd5, 8'd20, px);
        chk("post_reset_5_20", px, 16'h0000);
        probe(8'd0, 8'd100, px);
        chk("post_reset_snap_clear", px, 16'h0000);
        probe(8'd0, 8'd5, px);
        chk("post_reset_swatch", px, 16'hF800);

        // Snapshot isolation on ch1: 10 gives len 8
        in_0 = 8'd0;
        in_3 = 8'd0;
        in_1 = 8'd10;
        frame_start();
        probe(8'd20, 8'd23, px);
        chk("ch1_len8_in", px, 16'hFD20);
        probe(8'd20, 8'd25, px);
        chk("ch1_len8_out", px, 16'h0000);
        in_1 = 8'd200;
        probe(8'd20, 8'd30, px);
        chk("ch1_isolated", px, 16'h0000);
        // Holding (0,0) for several cycles gives a single pulse
        probe(8'd1, 8'd0, px);
        @(negedge clk);
        row = 8'd0;
        column = 8'd0;
        @(negedge clk);
        chk("tick_once_a", {15'd0, frame_tick}, 16'd1);
        @(negedge clk);
        chk("tick_once_b", {15'd0, frame_tick}, 16'd0);
        @(negedge clk);
        chk("tick_once_c", {15'd0, frame_tick}, 16'd0);
        repeat (10) @(negedge clk);
        probe(8'd20, 8'd30, px);
        chk("ch1_new_snap", px, 16'hFD20);

        // A second (0,0) arriving while peaks update is ignored
        in_1 = 8'd10;
        frame_start();
        probe(8'd1, 8'd0, px);
        @(negedge clk);
        row = 8'd0;
        column = 8'd0;
        @(negedge clk);
        chk("upd_first_tick", {15'd0, frame_tick}, 16'd1);
        column = 8'd1;
        @(negedge clk);
        in_1 = 8'd200;
        column = 8'd0;
        @(negedge clk);
        chk("upd_second_tick", {15'd0, frame_tick}, {15'd0, UPDT});
        column = 8'd1;
        repeat (12) @(negedge clk);
        probe(8'd20, 8'd30, px);
        chk("upd_snap_kept", px, UPDT ? 16'hFD20 : 16'h0000);

        // Peak hold and decay on ch2 (hold 2, decay 2)
        do_reset();
        in_1 = 8'd0;
        pk = 0;
        hd = 0;
        for (int f = 0; f < 106; f++) begin
            sv = (f == 0) ? 200 : 0;
            in_2 = 8'(sv);
            frame_start();
            if (sv >= pk) begin
                pk = sv;
                hd = 2;
            end else if (hd != 0) begin
                hd = hd - 1;
            end else begin
                pk = (pk < 2) ? 0 : pk - 2;
                if (sv > pk) pk = sv;
            end
            col = 16 + ((pk * 7) >> 3);
            probe(8'd33, 8'(col), px);
            chk($sformatf("peak_f%0d_col%0d", f, col), px, PK);
            if (f == 0) begin
                probe(8'd33, 8'd100, px);
                chk("ch2_bar_f0", px, 16'hFF40);
            end
        end
        probe(8'd33, 8'd189, px);
        chk("ch2_no_stale_marker", px, 16'h0000);

        // Saturation on ch4
        in_4 = 8'd255;
        for (int f = 0; f < 3; f++) begin
            frame_start();
            probe(8'd64, 8'd239, px);
            chk($sformatf("sat_marker_f%0d", f), px, PK);
            probe(8'd64, 8'd238, px);
            chk($sformatf("sat_bar_f%0d", f), px, 16'h07FD);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
